// File: rtl/junction_lamp_pkg.sv
// Shared types for the junction lamp scheduler: state codes, lamp encodings, direction.
// JUNCTION_NIGHT_FLASH_EN adds the FLASH state code.
package junction_lamp_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALLRED1   = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALLRED2   = 3'd5,
    ST_WALK      = 3'd6
`ifdef JUNCTION_NIGHT_FLASH_EN
    ,
    ST_FLASH     = 3'd7
`endif
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

endpackage

// File: rtl/junction_lamp_sched_phase_timer.sv
// Loadable down-counter that times each phase; done is high while the count is zero.
module phase_timer #(
  parameter int unsigned       CNT_W   = 8,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/junction_lamp_sched.sv
// Two-road junction lamp scheduler with pedestrian WALK insertion; all outputs registered.
// Optional night flashing mode is compiled in with JUNCTION_NIGHT_FLASH_EN.
module junction_lamp_sched
  import junction_lamp_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned WALK_CYC   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ped_req,
`ifdef JUNCTION_NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);

  function automatic logic [CNT_W-1:0] load_for(input state_e s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   load_for = GREEN_LD;
      ST_NS_YELLOW, ST_EW_YELLOW: load_for = YELLOW_LD;
      ST_WALK:                    load_for = WALK_LD;
`ifdef JUNCTION_NIGHT_FLASH_EN
      ST_FLASH:                   load_for = YELLOW_LD;
`endif
      default:                    load_for = ALLRED_LD;
    endcase
  endfunction

  state_e           state_q, state_d;
  dir_e             next_dir_q, next_dir_d;
  logic             ped_pend_q, ped_pend_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d;
  logic             walk_q, walk_d, ack_q, ack_d;
  logic             timer_done;
  logic [CNT_W-1:0] timer_load_val;
  logic             enter_walk;
`ifdef JUNCTION_NIGHT_FLASH_EN
  logic             flash_on_q, flash_on_d;
`endif

  // Every expiry either changes state or toggles the flash interval, so reload on done.
  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk        (clock),
    .rst_n      (reset_n),
    .load_i     (timer_done),
    .load_val_i (timer_load_val),
    .done_o     (timer_done)
  );

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
`ifdef JUNCTION_NIGHT_FLASH_EN
    flash_on_d = flash_on_q;
`endif
    if (timer_done) begin
      case (state_q)
        ST_NS_GREEN:  state_d = ST_NS_YELLOW;
        ST_NS_YELLOW: state_d = ST_ALLRED1;
        ST_EW_GREEN:  state_d = ST_EW_YELLOW;
        ST_EW_YELLOW: state_d = ST_ALLRED2;
        ST_ALLRED1, ST_ALLRED2: begin
`ifdef JUNCTION_NIGHT_FLASH_EN
          if (night) begin
            state_d    = ST_FLASH;
            flash_on_d = 1'b1;
          end else
`endif
          if (ped_pend_q) begin
            state_d    = ST_WALK;
            next_dir_d = (state_q == ST_ALLRED1) ? DIR_EW : DIR_NS;
          end else begin
            state_d = (state_q == ST_ALLRED1) ? ST_EW_GREEN : ST_NS_GREEN;
          end
        end
        ST_WALK: state_d = (next_dir_q == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;
`ifdef JUNCTION_NIGHT_FLASH_EN
        // Leave only at the end of a dark interval so the last flash is complete.
        ST_FLASH: begin
          if (flash_on_q)  flash_on_d = 1'b0;
          else if (!night) state_d    = ST_ALLRED2;
          else             flash_on_d = 1'b1;
        end
`endif
        default: state_d = ST_ALLRED2;
      endcase
    end
  end

  assign enter_walk     = (state_d == ST_WALK) && (state_q != ST_WALK);
  assign timer_load_val = load_for(state_d);
  assign ped_pend_d     = enter_walk ? 1'b0
                                     : (ped_pend_q | (ped_req & (state_q != ST_WALK)));

  // Lamps are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    ack_d  = enter_walk;
    case (state_d)
      ST_NS_GREEN:  ns_d = LAMP_GREEN;
      ST_NS_YELLOW: ns_d = LAMP_YELLOW;
      ST_EW_GREEN:  ew_d = LAMP_GREEN;
      ST_EW_YELLOW: ew_d = LAMP_YELLOW;
      ST_WALK:      walk_d = 1'b1;
`ifdef JUNCTION_NIGHT_FLASH_EN
      ST_FLASH: begin
        ns_d = flash_on_d ? LAMP_YELLOW : LAMP_OFF;
        ew_d = flash_on_d ? LAMP_YELLOW : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ALLRED2;
      next_dir_q <= DIR_NS;
      ped_pend_q <= 1'b0;
      ns_q       <= LAMP_RED;
      ew_q       <= LAMP_RED;
      walk_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_dir_q <= next_dir_d;
      ped_pend_q <= ped_pend_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
      ack_q      <= ack_d;
    end
  end

`ifdef JUNCTION_NIGHT_FLASH_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) flash_on_q <= 1'b0;
    else          flash_on_q <= flash_on_d;
  end
`endif

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign walk     = walk_q;
  assign ped_ack  = ack_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_junction_lamp_sched.sv
// Self-checking bench for junction_lamp_sched: base-ring table, directed pedestrian/reset
// sequences, and randomized requests against a phase/duration reference model.
module tb_junction_lamp_sched;

  localparam int GREEN = 8;
  localparam int YEL   = 2;
  localparam int AR    = 1;
  localparam int WALKC = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       ped_req = 1'b0;
`ifdef JUNCTION_NIGHT_FLASH_EN
  logic       night   = 1'b0;
`endif
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_ack;

  junction_lamp_sched #(
    .GREEN_CYC (GREEN), .YELLOW_CYC (YEL), .ALLRED_CYC (AR), .WALK_CYC (WALKC), .CNT_W (8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ped_req  (ped_req),
`ifdef JUNCTION_NIGHT_FLASH_EN
    .night    (night),
`endif
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .phase    (phase)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [11:0] out_log [0:511];

  // Reference model: phase number, cycles left in it, pending request, resume direction.
  int m_phase, m_left, m_dir;
  bit m_pend, m_ack;

  typedef struct {
    int         first;
    int         last;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic [2:0] phase;
  } base_row_t;
  base_row_t base_tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int dur_of(input int p);
    case (p)
      0, 3:    return GREEN;
      1, 4:    return YEL;
      6:       return WALKC;
      default: return AR;
    endcase
  endfunction

  function automatic logic [2:0] ns_of(input int p);
    case (p)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input int p);
    case (p)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 5; m_left = AR; m_dir = 0; m_pend = 0; m_ack = 0;
  endtask

  task automatic model_step();
    bit pend_new;
    int nxt;
    pend_new = m_pend || (ped_req && m_phase != 6);
    m_ack = 0;
    if (m_left > 1) begin
      m_left--;
    end else begin
      case (m_phase)
        2:       if (m_pend) begin nxt = 6; m_dir = 3; end else nxt = 3;
        5:       if (m_pend) begin nxt = 6; m_dir = 0; end else nxt = 0;
        6:       nxt = m_dir;
        default: nxt = m_phase + 1;
      endcase
      if (nxt == 6) begin
        pend_new = 0;
        m_ack    = 1;
      end
      m_phase = nxt;
      m_left  = dur_of(nxt);
    end
    m_pend = pend_new;
  endtask

  task automatic tick(input bit use_model);
    logic [11:0] act, exp;
    @(posedge clock);
    if (use_model) model_step();
    @(negedge clock);
    cyc++;
    act = {ns_light, ew_light, walk, ped_ack, phase};
    if (cyc < 512) out_log[cyc] = act;
    if (use_model) begin
      exp = {ns_of(m_phase), ew_of(m_phase), (m_phase == 6), m_ack, 3'(m_phase)};
      check("model_outputs", 32'(act), 32'(exp));
    end
    if (phase != 3'd7) check("both_nonred", 32'(ns_light != 3'b100 && ew_light != 3'b100), 32'd0);
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks outputs asynchronously, releases.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    ped_req = 1'b0;
    #1 check("reset_outputs", 32'({ns_light, ew_light, walk, ped_ack, phase}),
             32'({3'b100, 3'b100, 1'b0, 1'b0, 3'd5}));
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    int acks;
    base_tbl[0] = '{1,  8,  3'b001, 3'b100, 1'b0, 3'd0};
    base_tbl[1] = '{9,  10, 3'b010, 3'b100, 1'b0, 3'd1};
    base_tbl[2] = '{11, 11, 3'b100, 3'b100, 1'b0, 3'd2};
    base_tbl[3] = '{12, 19, 3'b100, 3'b001, 1'b0, 3'd3};
    base_tbl[4] = '{20, 21, 3'b100, 3'b010, 1'b0, 3'd4};
    base_tbl[5] = '{22, 22, 3'b100, 3'b100, 1'b0, 3'd5};
    base_tbl[6] = '{23, 23, 3'b001, 3'b100, 1'b0, 3'd0};

    @(negedge clock);
    do_reset();

    // Base ring with no requests.
    for (int c = 1; c <= 23; c++) begin
      tick(1'b1);
      for (int r = 0; r < 7; r++)
        if (c >= base_tbl[r].first && c <= base_tbl[r].last)
          check("base_ring", 32'({ns_light, ew_light, walk, phase}),
                32'({base_tbl[r].ns, base_tbl[r].ew, base_tbl[r].walk, base_tbl[r].phase}));
    end

    // One-cycle request during NS green: WALK after ALLRED1, then EW green, no WALK at ALLRED2.
    do_reset();
    repeat (3) tick(1'b1);
    ped_req = 1'b1;
    tick(1'b1);
    ped_req = 1'b0;
    repeat (24) tick(1'b1);
    check("pulse_allred1", 32'(out_log[11][2:0]), 32'd2);
    check("pulse_walk_start", 32'(out_log[12][4:0]), 32'({1'b1, 1'b1, 3'd6}));
    check("pulse_ack_once", 32'(out_log[13][3]), 32'd0);
    check("pulse_walk_end", 32'(out_log[15][4:0]), 32'({1'b1, 1'b0, 3'd6}));
    check("pulse_ew_green", 32'(out_log[16][10:0]), 32'({3'b100, 3'b001, 1'b0, 1'b0, 3'd3}));
    check("pulse_no_second_walk", 32'(out_log[27][2:0]), 32'd0);
    acks = 0;
    for (int c = 1; c <= 28; c++) acks += int'(out_log[c][3]);
    check("pulse_ack_count", 32'(acks), 32'd1);

    // Request held high: WALK at every ALLRED, one ack per WALK.
    do_reset();
    ped_req = 1'b1;
    repeat (50) tick(1'b1);
    ped_req = 1'b0;
    check("hold_walk_a", 32'(out_log[12][2:0]), 32'd6);
    check("hold_walk_b", 32'(out_log[27][2:0]), 32'd6);
    check("hold_walk_c", 32'(out_log[42][2:0]), 32'd6);
    acks = 0;
    for (int c = 1; c <= 50; c++) acks += int'(out_log[c][3]);
    check("hold_ack_count", 32'(acks), 32'd3);

    // Request arriving on the cycle ALLRED2 expires is served one ALLRED later.
    do_reset();
    repeat (22) tick(1'b1);
    ped_req = 1'b1;
    tick(1'b1);
    ped_req = 1'b0;
    repeat (17) tick(1'b1);
    check("late_req_not_served", 32'(out_log[23][2:0]), 32'd0);
    check("late_req_served", 32'(out_log[34][4:0]), 32'({1'b1, 1'b1, 3'd6}));

    // Reset mid EW green with a pending request discards it.
    do_reset();
    repeat (13) tick(1'b1);
    ped_req = 1'b1;
    tick(1'b1);
    ped_req = 1'b0;
    tick(1'b1);
    do_reset();
    repeat (13) tick(1'b1);
    check("reset_drop_allred1", 32'(out_log[11][2:0]), 32'd2);
    check("reset_drop_no_walk", 32'(out_log[12][2:0]), 32'd3);

    // Randomized requests against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ped_req = ($urandom_range(0, 2) == 0);
      tick(1'b1);
    end
    ped_req = 1'b0;

`ifdef JUNCTION_NIGHT_FLASH_EN
    // Night flashing: enters at ALLRED1, leaves after an off interval via ALLRED2.
    do_reset();
    tick(1'b0);
    night = 1'b1;
    repeat (15) tick(1'b0);
    night = 1'b0;
    repeat (6) tick(1'b0);
    check("flash_on_a", 32'(out_log[12][10:0]), 32'({3'b010, 3'b010, 1'b0, 1'b0, 3'd7}));
    check("flash_on_b", 32'(out_log[13][10:5]), 32'({3'b010, 3'b010}));
    check("flash_off_a", 32'(out_log[14][10:0]), 32'({3'b000, 3'b000, 1'b0, 1'b0, 3'd7}));
    check("flash_off_b", 32'(out_log[15][10:5]), 32'd0);
    check("flash_on_c", 32'(out_log[16][10:5]), 32'({3'b010, 3'b010}));
    check("flash_last_off", 32'(out_log[19][10:0]), 32'({3'b000, 3'b000, 1'b0, 1'b0, 3'd7}));
    check("flash_exit_allred2", 32'(out_log[20][2:0]), 32'd5);
    check("flash_then_ns_green", 32'(out_log[21][2:0]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
